dmem_mmio_responder: RTL and testbench
======================================

// Module: dmem_mmio_responder
// PURPOSE
//  Responder side of the core's M-stage data port (memWriteM/ALUResultM/writeDataM -> readDataM).
//  Decodes the word address, serves a word RAM plus memory-mapped GPIO, free-running timer
//  and 8N1 UART transmitter. Combinational read for same-cycle readDataM; writes commit on clk.
// PARAMETERS
//  RAM_WORDS      1024   data RAM depth in 32-bit words (power of 2, <= 1024)
//  CLKS_PER_BIT   868    clk cycles per UART bit (>= 2)
//  GPIO_W         8      width of gpio_out
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high reset
//  memWriteM    in   1       store strobe for current cycle
//  ALUResultM   in   32      byte address; bits[1:0] ignored (word access only)
//  writeDataM   in   32      store data
//  readDataM    out  32      load data, combinational from ALUResultM
//  gpio_out     out  GPIO_W  GPIO output register
//  uart_tx      out  1       serial line, idle high
//  bus_err      out  1       sticky: access to unmapped address seen
// BEHAVIOUR
//  Map (addr[31:28], addr[11:2]):
//   0x0000_0000..0x0000_0FFF RAM, index addr[11:2] mod RAM_WORDS; RW.
//   0x1000_0000 GPIO   RW; read = {zero-ext, gpio_out}; write loads writeDataM[GPIO_W-1:0].
//   0x1000_0004 TIMER  RW; +1 every cycle, wraps 0xFFFF_FFFF->0; write loads writeDataM
//                      (write wins over increment; next cycle reads written value, then +1).
//   0x1000_0008 TXDATA WO (reads 0); write when !busy launches frame with writeDataM[7:0];
//                      write when busy is dropped and sets overrun.
//   0x1000_000C STATUS read {30'b0, overrun, busy}; write with writeDataM[1]=1 clears overrun.
//   Any other address: read 0; any access (read or write) with memWriteM or load sets bus_err?
//   -> decided: bus_err sets only on memWriteM=1 to unmapped address; reads return 0 silently.
//  Reset values: gpio_out=0, timer=0, uart_tx=1, busy=0, overrun=0, bus_err=0, FSM=IDLE.
//  RAM contents NOT reset; reset does not block reads; writes during reset are ignored.
//  Write latency: 1 cycle (value visible to combinational read the cycle after memWriteM).
//  UART FSM (IDLE, START, DATA, STOP); bit counter 0..7 LSB first, baud counter 0..CLKS_PER_BIT-1:
//   IDLE : uart_tx=1, busy=0; TXDATA write -> latch byte, START.
//   START: uart_tx=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA : uart_tx=byte[bit] per bit period; after bit 7 -> STOP.
//   STOP : uart_tx=1 for CLKS_PER_BIT cycles -> IDLE.
//   busy=1 from cycle after launching write through last STOP cycle; frame = 10*CLKS_PER_BIT.
//   TXDATA write in final STOP cycle counts as busy -> dropped, overrun=1.
//   Simultaneous overrun-set and STATUS clear impossible (one access/cycle); set vs clear n/a.
//  Reset mid-frame: next cycle uart_tx=1, FSM=IDLE, byte discarded.
// STRUCTURE
//  mmio_pkg: address constants (RAM/GPIO/TIMER/TXDATA/STATUS), region decode mask,
//   uart_state_t enum {IDLE,START,DATA,STOP}.
//  Sub-module uart_tx_serializer (clk, reset, start, data[7:0] -> tx, busy); top holds RAM,
//   decode, GPIO, timer, overrun, bus_err, read mux.
// TESTING
//  1 Store 0xA5A5_1234 to 0x0000_0010, load same addr next cycle -> readDataM=0xA5A5_1234;
//    load 0x0000_0013 -> same value (bits[1:0] ignored).
//  2 Reset 3 cycles, read TIMER at cycles 1,2,3 after release -> 0,1,2; write 0xFFFF_FFFE,
//    reads next two cycles -> 0xFFFF_FFFE, 0xFFFF_FFFF, then 0x0000_0000.
//  3 CLKS_PER_BIT=4: write 0x55 to TXDATA -> uart_tx 0 for 4 cycles, then 1,0,1,0,1,0,1,0
//    each 4 cycles, 1 for 4; STATUS busy=1 for exactly 40 cycles.
//  4 Second TXDATA write 10 cycles into frame -> frame unchanged, STATUS=0x3; write STATUS
//    0x2 -> STATUS=0x1 while busy, 0x0 after frame.
//  5 Assert reset mid DATA bit -> uart_tx=1 and STATUS=0 next cycle; gpio_out=0.
//  6 Store to 0x2000_0000 -> bus_err=1 and stays 1; load 0x2000_0000 -> readDataM=0,
//    GPIO store 0xFF then read -> 0x0000_00FF (GPIO_W=8).

Source files
------------

// File: rtl/mmio_pkg.sv
// Address map constants and shared types for the M-stage data responder.
// Peripheral addresses are word aligned; callers compare against the address with bits[1:0] cleared.
package mmio_pkg;

  localparam logic [31:0] ADDR_RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] RAM_REGION_MASK = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_GPIO       = 32'h1000_0000;
  localparam logic [31:0] ADDR_TIMER      = 32'h1000_0004;
  localparam logic [31:0] ADDR_TXDATA     = 32'h1000_0008;
  localparam logic [31:0] ADDR_STATUS     = 32'h1000_000C;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: one start bit, eight data bits LSB first, one stop bit.
// busy covers the whole frame and drops together with the return to IDLE.
module uart_tx_serializer
  import mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_t   r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;
  logic          w_baud_done;

  assign w_baud_done = (r_baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= UART_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        UART_IDLE: begin
          r_tx <= 1'b1;
          if (start) begin
            r_shift <= data;
            r_baud  <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= UART_START;
          end
        end
        UART_START: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= UART_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        UART_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= UART_STOP;
            end else begin
              // Shift register keeps the next bit at [1] so tx can be loaded registered.
              r_bit   <= r_bit + 1'b1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        UART_STOP: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_busy  <= 1'b0;
            r_state <= UART_IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= UART_IDLE;
        end
      endcase
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;

endmodule

// File: rtl/dmem_mmio_responder.sv
// M-stage data port responder: word RAM plus GPIO, free-running timer and UART TX registers.
// Loads are combinational from ALUResultM; stores commit on the clock edge ending the cycle.
module dmem_mmio_responder
  import mmio_pkg::*;
#(
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 868,
  parameter int GPIO_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memWriteM,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       writeDataM,
  output logic [31:0]       readDataM,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              uart_tx,
  output logic              bus_err
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [31:0]       r_ram [RAM_WORDS];
  logic [GPIO_W-1:0] r_gpio;
  logic [31:0]       r_timer;
  logic              r_overrun;
  logic              r_bus_err;

  logic [31:0]       w_word_addr;
  logic [AW-1:0]     w_ram_idx;
  logic              w_sel_ram;
  logic              w_sel_gpio;
  logic              w_sel_timer;
  logic              w_sel_txdata;
  logic              w_sel_status;
  logic              w_unmapped;
  logic              w_wr;
  logic              w_uart_busy;
  logic              w_uart_start;
  logic [31:0]       w_read_data;
  logic              w_unused_addr;

  assign w_word_addr  = word_align(ALUResultM);
  assign w_ram_idx    = ALUResultM[AW+1:2];
  assign w_sel_ram    = ((ALUResultM & RAM_REGION_MASK) == ADDR_RAM_BASE);
  assign w_sel_gpio   = (w_word_addr == ADDR_GPIO);
  assign w_sel_timer  = (w_word_addr == ADDR_TIMER);
  assign w_sel_txdata = (w_word_addr == ADDR_TXDATA);
  assign w_sel_status = (w_word_addr == ADDR_STATUS);
  assign w_unmapped   = !(w_sel_ram || w_sel_gpio || w_sel_timer || w_sel_txdata || w_sel_status);
  assign w_unused_addr = ^{ALUResultM[11:0]};

  // Stores presented while reset is high are discarded everywhere, RAM included.
  assign w_wr = memWriteM && !reset;

  // A launch attempt while a frame is in flight is dropped and flagged as overrun.
  assign w_uart_start = w_wr && w_sel_txdata && !w_uart_busy;

  always_ff @(posedge clk) begin
    if (w_wr && w_sel_ram) begin
      r_ram[w_ram_idx] <= writeDataM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gpio    <= '0;
      r_timer   <= '0;
      r_overrun <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_wr && w_sel_gpio) begin
        r_gpio <= writeDataM[GPIO_W-1:0];
      end
      if (w_wr && w_sel_timer) begin
        r_timer <= writeDataM;
      end else begin
        r_timer <= r_timer + 32'd1;
      end
      if (w_wr && w_sel_txdata && w_uart_busy) begin
        r_overrun <= 1'b1;
      end else if (w_wr && w_sel_status && writeDataM[1]) begin
        r_overrun <= 1'b0;
      end
      if (w_wr && w_unmapped) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk   (clk),
    .reset (reset),
    .start (w_uart_start),
    .data  (writeDataM[7:0]),
    .tx    (uart_tx),
    .busy  (w_uart_busy)
  );

  always_comb begin
    w_read_data = '0;
    if (w_sel_ram) begin
      w_read_data = r_ram[w_ram_idx];
    end else if (w_sel_gpio) begin
      w_read_data = 32'(r_gpio);
    end else if (w_sel_timer) begin
      w_read_data = r_timer;
    end else if (w_sel_status) begin
      w_read_data = {30'b0, r_overrun, w_uart_busy};
    end
  end

  assign readDataM = w_read_data;
  assign gpio_out  = r_gpio;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder with a short UART bit period (4 clocks).
// Each scenario task drives its own stimulus and checks against hand-derived values.
module tb_dmem_mmio_responder;

  localparam int CPB = 4;
  localparam logic [31:0] A_GPIO   = 32'h1000_0000;
  localparam logic [31:0] A_TIMER  = 32'h1000_0004;
  localparam logic [31:0] A_TXDATA = 32'h1000_0008;
  localparam logic [31:0] A_STATUS = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memWriteM = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] writeDataM = '0;
  logic [31:0] readDataM;
  logic [7:0]  gpio_out;
  logic        uart_tx;
  logic        bus_err;

  int n_cmp = 0;
  int n_err = 0;

  dmem_mmio_responder #(
    .RAM_WORDS    (1024),
    .CLKS_PER_BIT (CPB),
    .GPIO_W       (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memWriteM  (memWriteM),
    .ALUResultM (ALUResultM),
    .writeDataM (writeDataM),
    .readDataM  (readDataM),
    .gpio_out   (gpio_out),
    .uart_tx    (uart_tx),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    memWriteM  = 1'b1;
    ALUResultM = addr;
    writeDataM = data;
    step();
    memWriteM  = 1'b0;
    #1;
  endtask

  task automatic rd(input logic [31:0] addr);
    memWriteM  = 1'b0;
    ALUResultM = addr;
    #1;
  endtask

  // Expected line level k cycles after a launch edge for byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k < CPB) return 1'b0;
    if (k >= 9 * CPB) return 1'b1;
    return b[(k / CPB) - 1];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    rd(A_STATUS);
    n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
    n_cmp++; if (gpio_out !== 8'h00) begin n_err++; $display("FAIL reset_gpio: got %h expected 00", gpio_out); end
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
    n_cmp++; if (readDataM !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h expected 00000000", readDataM); end
    $display("reset: status=%h uart_tx=%b gpio=%h bus_err=%b", readDataM, uart_tx, gpio_out, bus_err);
  endtask

  task automatic test_ram();
    wr(32'h0000_0010, 32'hA5A5_1234);
    rd(32'h0000_0010);
    n_cmp++; if (readDataM !== 32'hA5A5_1234) begin n_err++; $display("FAIL ram_read: got %h expected a5a51234", readDataM); end
    rd(32'h0000_0013);
    n_cmp++; if (readDataM !== 32'hA5A5_1234) begin n_err++; $display("FAIL ram_read_unaligned: got %h expected a5a51234", readDataM); end
    wr(32'h0000_0020, 32'h1111_1111);
    rd(32'h0000_0020);
    n_cmp++; if (readDataM !== 32'h1111_1111) begin n_err++; $display("FAIL ram_read2: got %h expected 11111111", readDataM); end
    rd(32'h0000_0010);
    n_cmp++; if (readDataM !== 32'hA5A5_1234) begin n_err++; $display("FAIL ram_no_alias: got %h expected a5a51234", readDataM); end
    $display("ram: stored/loaded words at 0x10 and 0x20");
  endtask

  task automatic test_timer();
    logic [31:0] exp_t [3];
    exp_t[0] = 32'hFFFF_FFFE; exp_t[1] = 32'hFFFF_FFFF; exp_t[2] = 32'h0000_0000;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    rd(A_TIMER);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (readDataM !== 32'(i)) begin n_err++; $display("FAIL timer_after_reset_%0d: got %h expected %h", i, readDataM, 32'(i)); end
      $display("timer: cycle %0d after release reads %h", i + 1, readDataM);
      step();
    end
    wr(A_TIMER, 32'hFFFF_FFFE);
    rd(A_TIMER);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (readDataM !== exp_t[i]) begin n_err++; $display("FAIL timer_wrap_%0d: got %h expected %h", i, readDataM, exp_t[i]); end
      $display("timer: read %0d after load reads %h", i, readDataM);
      step();
    end
  endtask

  task automatic test_uart_frame();
    logic [7:0] b;
    b = 8'h55;
    wr(A_TXDATA, {24'h0, b});
    for (int k = 0; k <= 10 * CPB; k++) begin
      rd(A_STATUS);
      n_cmp++; if (uart_tx !== frame_bit(b, k)) begin n_err++; $display("FAIL frame55_tx_k%0d: got %b expected %b", k, uart_tx, frame_bit(b, k)); end
      n_cmp++; if (readDataM !== {31'h0, (k < 10 * CPB)}) begin n_err++; $display("FAIL frame55_busy_k%0d: got %h expected %h", k, readDataM, {31'h0, (k < 10 * CPB)}); end
      step();
    end
    rd(A_TXDATA);
    n_cmp++; if (readDataM !== 32'h0) begin n_err++; $display("FAIL txdata_reads_zero: got %h expected 00000000", readDataM); end
    $display("uart: frame 0x55 observed over %0d cycles", 10 * CPB);
  endtask

  task automatic test_overrun();
    logic [7:0]  b;
    logic [31:0] exp_st;
    b = 8'hA3;
    wr(A_TXDATA, {24'h0, b});
    for (int k = 0; k <= 10 * CPB; k++) begin
      if (k == 10) begin
        memWriteM = 1'b1; ALUResultM = A_TXDATA; writeDataM = 32'h0000_00FF; #1;
      end else if (k == 15) begin
        memWriteM = 1'b1; ALUResultM = A_STATUS; writeDataM = 32'h0000_0002; #1;
      end else begin
        rd(A_STATUS);
        exp_st = {30'h0, (k >= 11 && k < 15), (k < 10 * CPB)};
        n_cmp++; if (readDataM !== exp_st) begin n_err++; $display("FAIL overrun_status_k%0d: got %h expected %h", k, readDataM, exp_st); end
      end
      n_cmp++; if (uart_tx !== frame_bit(b, k)) begin n_err++; $display("FAIL overrun_tx_k%0d: got %b expected %b", k, uart_tx, frame_bit(b, k)); end
      step();
      memWriteM = 1'b0;
    end
    $display("uart: frame 0xA3 kept through dropped write, overrun set then cleared");
  endtask

  task automatic test_reset_mid_frame();
    wr(A_GPIO, 32'h0000_005A);
    n_cmp++; if (gpio_out !== 8'h5A) begin n_err++; $display("FAIL gpio_load: got %h expected 5a", gpio_out); end
    wr(A_TXDATA, 32'h0000_0000);
    repeat (6) step();
    rd(A_STATUS);
    n_cmp++; if (uart_tx !== 1'b0) begin n_err++; $display("FAIL mid_data_tx: got %b expected 0", uart_tx); end
    reset = 1'b1;
    memWriteM = 1'b1; ALUResultM = 32'h0000_0020; writeDataM = 32'h2222_2222;
    step();
    memWriteM = 1'b0;
    rd(A_STATUS);
    n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL reset_mid_tx: got %b expected 1", uart_tx); end
    n_cmp++; if (readDataM !== 32'h0) begin n_err++; $display("FAIL reset_mid_status: got %h expected 00000000", readDataM); end
    n_cmp++; if (gpio_out !== 8'h00) begin n_err++; $display("FAIL reset_mid_gpio: got %h expected 00", gpio_out); end
    rd(32'h0000_0020);
    n_cmp++; if (readDataM !== 32'h1111_1111) begin n_err++; $display("FAIL write_during_reset: got %h expected 11111111", readDataM); end
    reset = 1'b0;
    rd(A_STATUS);
    for (int i = 0; i < 2 * CPB; i++) begin
      step();
      n_cmp++; if (uart_tx !== 1'b1 || readDataM !== 32'h0) begin n_err++; $display("FAIL post_reset_idle_%0d: got tx=%b status=%h expected tx=1 status=00000000", i, uart_tx, readDataM); end
    end
    $display("reset mid-frame: line idle, byte discarded, gpio cleared");
  endtask

  task automatic test_bus_err_gpio();
    rd(32'h1000_0010);
    n_cmp++; if (readDataM !== 32'h0) begin n_err++; $display("FAIL unmapped_read: got %h expected 00000000", readDataM); end
    step();
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL read_no_bus_err: got %b expected 0", bus_err); end
    wr(32'h2000_0000, 32'hDEAD_BEEF);
    n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL bus_err_set: got %b expected 1", bus_err); end
    rd(32'h2000_0000);
    n_cmp++; if (readDataM !== 32'h0) begin n_err++; $display("FAIL unmapped_read2: got %h expected 00000000", readDataM); end
    wr(A_GPIO, 32'h1234_56FF);
    rd(A_GPIO);
    n_cmp++; if (readDataM !== 32'h0000_00FF) begin n_err++; $display("FAIL gpio_read: got %h expected 000000ff", readDataM); end
    n_cmp++; if (gpio_out !== 8'hFF) begin n_err++; $display("FAIL gpio_out: got %h expected ff", gpio_out); end
    repeat (3) step();
    n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL bus_err_sticky: got %b expected 1", bus_err); end
    $display("bus_err: sticky after unmapped store, gpio=%h", gpio_out);
  endtask

  initial begin
    test_reset();
    test_ram();
    test_timer();
    test_uart_frame();
    test_overrun();
    test_reset_mid_frame();
    test_bus_err_gpio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
